booth_r4_mult: RTL
==================

BOOTH_R4_MULT -- requirements
Module: booth_r4_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and at least 4.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 Port: multiplicand  input  WIDTH  signed two's-complement operand M; captured on accepted start.
REQ-006 Port: multiplier  input  WIDTH  signed two's-complement operand Q; captured on accepted start.
REQ-007 Port: busy  output  1  high while in CALC or DONE.
REQ-008 Port: done  output  1  one-cycle pulse; product valid.
REQ-009 Port: product  output  2*WIDTH  signed result M*Q; holds until next accepted start or reset.
REQ-010 Port: count  output  4  remaining Booth iterations (radix-4 down-counter).

Function
REQ-011 FSM states SHALL be IDLE, CALC and DONE only.
REQ-012 IDLE with start=1: latch M and Q, clear accumulator A (WIDTH+2 bits) and q_-1, load count=WIDTH/2, clear product, go to CALC.
REQ-013 IDLE with start=0: hold all registers.
REQ-014 Each CALC cycle: Booth-encode the triplet {Q[1],Q[0],q_-1}.
- 000/111 -> +0
- 001/010 -> +M
- 011 -> +2M
- 100 -> -2M
- 101/110 -> -M
- M sign-extended to WIDTH+2 bits before the add.
REQ-015 In the same cycle: arithmetic right shift by 2 of the concatenation {A,Q,q_-1}, and count decrements by 1.
REQ-016 CALC cycle with count==1: shift completes, count becomes 0, product loads {A[WIDTH-1:0],Q}, go to DONE.
REQ-017 DONE: assert done=1 for exactly that cycle, then go to IDLE unconditionally.
REQ-018 Latency: start accepted at edge N; done high during cycle N+WIDTH/2+1; busy high for WIDTH/2+1 cycles.
REQ-019 start while busy=1 (CALC or DONE) SHALL be ignored; operand inputs SHALL not affect an ongoing operation.
REQ-020 count values SHALL follow WIDTH/2, WIDTH/2-1, ..., 1 during CALC, and 0 in DONE and IDLE after completion.
REQ-021 count SHALL never wrap below 0.
REQ-022 Result SHALL be exact for all operand pairs, including M=Q=-2^(WIDTH-1) (result +2^(2*WIDTH-2)), with no overflow.

Reset
REQ-023 rst=1 at a rising edge, in any state: state=IDLE, busy=0, done=0, product=0, count=0, A=0, q_-1=0.
REQ-024 rst SHALL take priority over start.
REQ-025 rst asserted mid-CALC SHALL abort the operation with no done pulse.

Verification
REQ-026 WIDTH=8, M=7, Q=3, start one cycle -> count 4,3,2,1 then 0; done in 5th cycle after accept; product=0x0015.
REQ-027 M=-128, Q=-128 -> product=0x4000 (16384); M=127, Q=-128 -> product=0xC080 (-16256).
REQ-028 M=-5, Q=7 -> product=0xFFDD (-35); M=0, Q=-1 -> product=0x0000.
REQ-029 start held high through a full operation with operands changed mid-CALC -> first result unaffected; next operation accepted only in the cycle after done.
REQ-030 rst pulsed during the 2nd CALC cycle -> busy=0, count=0, product=0 next cycle; no done pulse.
REQ-031 Random signed operand pairs (at least 1000) -> product equals the reference signed multiply; done pulse width exactly 1 cycle.

Source files
------------

// File: rtl/booth_r4_mult.sv
// Radix-4 Booth sequential signed multiplier.
// Each CALC cycle retires two multiplier bits, so a WIDTH x WIDTH product
// takes WIDTH/2 iterations. The accumulator is WIDTH+2 bits wide so that
// +/-2M and the most negative operands never overflow.
module booth_r4_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [3:0]           count
);

  localparam logic [3:0] HALF = 4'(WIDTH / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_accept;
  logic                 w_step;

  logic [WIDTH+1:0]     r_a;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_m;
  logic                 r_qm1;
  logic [3:0]           r_count;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH+1:0]     w_m_ext;
  logic [WIDTH+1:0]     w_m2_ext;
  logic [WIDTH+1:0]     w_addend;
  logic [WIDTH+1:0]     w_sum;
  logic [2*WIDTH+2:0]   w_cat;
  logic [2*WIDTH+2:0]   w_shr;
  logic [WIDTH+1:0]     w_a_nxt;
  logic [WIDTH-1:0]     w_q_nxt;
  logic                 w_qm1_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and status outputs.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end
      end
      S_CALC: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_count == 4'd1) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_m_ext  = {{2{r_m[WIDTH-1]}}, r_m};
  assign w_m2_ext = {w_m_ext[WIDTH:0], 1'b0};

  // Booth recoding of {Q[1],Q[0],q_-1} into the accumulator addend.
  always_comb begin
    w_addend = '0;
    case ({r_q[1:0], r_qm1})
      3'b001, 3'b010: w_addend = w_m_ext;
      3'b011:         w_addend = w_m2_ext;
      3'b100:         w_addend = -w_m2_ext;
      3'b101, 3'b110: w_addend = -w_m_ext;
      default:        w_addend = '0;
    endcase
  end

  // Add, then arithmetic shift right by 2 over the whole {A,Q,q_-1} chain.
  assign w_sum     = r_a + w_addend;
  assign w_cat     = {w_sum, r_q, r_qm1};
  assign w_shr     = {{2{w_cat[2*WIDTH+2]}}, w_cat[2*WIDTH+2:2]};
  assign w_a_nxt   = w_shr[2*WIDTH+2:WIDTH+1];
  assign w_q_nxt   = w_shr[WIDTH:1];
  assign w_qm1_nxt = w_shr[0];

  // Datapath: operand capture, iteration, and result load on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_qm1     <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_m       <= multiplicand;
      r_q       <= multiplier;
      r_a       <= '0;
      r_qm1     <= 1'b0;
      r_count   <= HALF;
      r_product <= '0;
    end else if (w_step) begin
      r_a   <= w_a_nxt;
      r_q   <= w_q_nxt;
      r_qm1 <= w_qm1_nxt;
      if (r_count != 4'd0) r_count <= r_count - 4'd1;
      if (r_count == 4'd1) r_product <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
    end
  end

  assign product = r_product;
  assign count   = r_count;

endmodule
